// File: rtl/me_mem_loader_pkg.sv
// Shared constants and state encoding for the motion-estimation memory loader.
// Geometry, word packing and the loader FSM states live here so all files agree.
package me_pkg;

    localparam int PIX_W        = 8;
    localparam int D_WIDTH      = 64;
    localparam int REF_WORDS    = 128;
    localparam int CUR_WORDS    = 32;
    localparam int REF_AW       = 7;
    localparam int CUR_AW       = 5;
    localparam int PIX_PER_WORD = D_WIDTH / PIX_W;
    localparam int IDX_W        = 3;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PIX_PER_WORD - 1);
    localparam logic [REF_AW-1:0] REF_LAST = REF_AW'(REF_WORDS - 1);
    localparam logic [CUR_AW-1:0] CUR_LAST = CUR_AW'(CUR_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_REF,
        LOAD_CUR,
        FIRE,
        WAIT_DONE
    } state_t;

endpackage

// File: rtl/me_mem_loader_packer.sv
// Packs accepted pixels MSB-first into 64-bit words; flags the completing pixel
// combinationally so the owner can register the write in the following cycle.
module pixel_packer
    import me_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_accept,
    input  logic [PIX_W-1:0]   i_pix,
    output logic               o_word_valid,
    output logic [D_WIDTH-1:0] o_word_data
);

    logic [D_WIDTH-PIX_W-1:0] r_shift;
    logic [IDX_W-1:0]         r_idx;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_accept) begin
            r_shift <= {r_shift[D_WIDTH-2*PIX_W-1:0], i_pix};
            r_idx   <= r_idx + 1'b1;
        end
    end

    // Clear beats completion: an aborted 8th pixel never yields a word.
    assign o_word_valid = i_accept && !i_clear && (r_idx == LAST_IDX);
    assign o_word_data  = {r_shift, i_pix};

endmodule

// File: rtl/me_mem_loader.sv
// Loader FSM: streams the reference window and current block into the
// engine's memories, then pulses go and waits for the engine to finish.
module me_mem_loader
    import me_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic               ref_skip,
    input  logic               load_abort,
    input  logic [PIX_W-1:0]   pix_data,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [REF_AW-1:0]  address_write_ref,
    output logic [D_WIDTH-1:0] data_write_ref,
    output logic               write_enable_ref,
    output logic [CUR_AW-1:0]  address_write_cur,
    output logic [D_WIDTH-1:0] data_write_cur,
    output logic               write_enable_cur,
    output logic               go,
    input  logic               me_done,
    output logic               busy
);

    state_t               r_state;
    logic [REF_AW-1:0]    r_ref_cnt;
    logic [CUR_AW-1:0]    r_cur_cnt;
    logic                 r_go;
    logic                 r_we_ref;
    logic                 r_we_cur;
    logic [REF_AW-1:0]    r_addr_ref;
    logic [CUR_AW-1:0]    r_addr_cur;
    logic [D_WIDTH-1:0]   r_data_ref;
    logic [D_WIDTH-1:0]   r_data_cur;

    logic                 w_accept;
    logic                 w_abort;
    logic                 w_word_valid;
    logic [D_WIDTH-1:0]   w_word_data;

    assign pix_ready = (r_state == LOAD_REF) || (r_state == LOAD_CUR);
    assign busy      = (r_state != IDLE);
    assign w_accept  = pix_valid && pix_ready;
    assign w_abort   = load_abort && (r_state != IDLE);

    pixel_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_abort),
        .i_accept     (w_accept),
        .i_pix        (pix_data),
        .o_word_valid (w_word_valid),
        .o_word_data  (w_word_data)
    );

    // NOTE: only the loader's own registers are reset; the memories behind
    // the write ports keep their contents across reset and abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ref_cnt  <= '0;
            r_cur_cnt  <= '0;
            r_go       <= 1'b0;
            r_we_ref   <= 1'b0;
            r_we_cur   <= 1'b0;
            r_addr_ref <= '0;
            r_addr_cur <= '0;
            r_data_ref <= '0;
            r_data_cur <= '0;
        end else begin
            r_we_ref <= 1'b0;
            r_we_cur <= 1'b0;
            r_go     <= 1'b0;
            if (w_abort) begin
                r_state   <= IDLE;
                r_ref_cnt <= '0;
                r_cur_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (load_start) r_state <= ref_skip ? LOAD_CUR : LOAD_REF;
                    end
                    LOAD_REF: begin
                        if (w_word_valid) begin
                            r_we_ref   <= 1'b1;
                            r_addr_ref <= r_ref_cnt;
                            r_data_ref <= w_word_data;
                            if (r_ref_cnt == REF_LAST) begin
                                r_ref_cnt <= '0;
                                r_state   <= LOAD_CUR;
                            end else begin
                                r_ref_cnt <= r_ref_cnt + 1'b1;
                            end
                        end
                    end
                    LOAD_CUR: begin
                        if (w_word_valid) begin
                            r_we_cur   <= 1'b1;
                            r_addr_cur <= r_cur_cnt;
                            r_data_cur <= w_word_data;
                            if (r_cur_cnt == CUR_LAST) begin
                                r_cur_cnt <= '0;
                                r_state   <= FIRE;
                            end else begin
                                r_cur_cnt <= r_cur_cnt + 1'b1;
                            end
                        end
                    end
                    FIRE: begin
                        // go lands one cycle after the last cur write has committed.
                        r_go    <= 1'b1;
                        r_state <= WAIT_DONE;
                    end
                    WAIT_DONE: begin
                        if (me_done) r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign go                = r_go;
    assign write_enable_ref  = r_we_ref;
    assign write_enable_cur  = r_we_cur;
    assign address_write_ref = r_addr_ref;
    assign address_write_cur = r_addr_cur;
    assign data_write_ref    = r_data_ref;
    assign data_write_cur    = r_data_cur;

endmodule
